// File: rtl/brick_pkg.sv
// Shared constants and state encoding for the brick sprite read path.
package brick_pkg;

  localparam int DEF_SPR_W = 60;
  localparam int DEF_SPR_H = 45;
  localparam int ADDR_W    = 19;
  localparam int PIX_W     = 10;

  localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BAND = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/brick_addr_gen.sv
// Raster-tracking address generator: walks sprite rows/columns incrementally
// (no multiplier) and registers the RAM read address plus the first hit stage.
module brick_addr_gen
  import brick_pkg::*;
#(
  parameter int SPR_W = DEF_SPR_W,
  parameter int SPR_H = DEF_SPR_H
)
(
  input  logic              CLK,
  input  logic              Reset,
  input  logic [PIX_W-1:0]  DrawX,
  input  logic [PIX_W-1:0]  DrawY,
  input  logic              blank_n,
  input  logic [PIX_W-1:0]  SprX,
  input  logic [PIX_W-1:0]  SprY,
  output logic [ADDR_W-1:0] READ_ADDR,
  output logic              hit_s1
);

  localparam int ROW_W = $clog2(SPR_H);
  localparam int COL_W = $clog2(SPR_W);

  state_t              state_q, state_d, state_eff;
  logic [ROW_W-1:0]    row_q, row_d, row_eff;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ADDR_W-1:0]   base_q, base_d, base_eff, addr_d;
  logic [PIX_W-1:0]    sprx_q, sprx_d;
  logic                issue;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      base_q    <= '0;
      sprx_q    <= '0;
      READ_ADDR <= '0;
      hit_s1    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      base_q  <= base_d;
      sprx_q  <= sprx_d;
      hit_s1  <= issue;
      if (issue) READ_ADDR <= addr_d;
    end
  end

  // Line-start bookkeeping is resolved first so a sprite at column 0 can
  // start its run on the very pixel that advanced the row.
  always_comb begin
    state_eff = state_q;
    row_eff   = row_q;
    base_eff  = base_q;
    sprx_d    = sprx_q;
    state_d   = state_q;
    row_d     = row_q;
    base_d    = base_q;
    col_d     = col_q;
    issue     = 1'b0;
    addr_d    = base_q;
    if (blank_n) begin
      if (DrawX == '0) begin
        sprx_d = SprX;
        if (DrawY == SprY) begin
          state_eff = BAND;
          row_eff   = '0;
          base_eff  = '0;
        end else if (state_q != IDLE && row_q < ROW_W'(SPR_H - 1)) begin
          state_eff = BAND;
          row_eff   = row_q + 1'b1;
          base_eff  = base_q + ADDR_W'(SPR_W);
        end else begin
          state_eff = IDLE;
        end
      end
      state_d = state_eff;
      row_d   = row_eff;
      base_d  = base_eff;
      case (state_eff)
        BAND: begin
          if (DrawX == sprx_d) begin
            issue   = 1'b1;
            addr_d  = base_eff;
            col_d   = COL_W'(1);
            state_d = RUN;
          end
        end
        RUN: begin
          issue  = 1'b1;
          addr_d = base_eff + ADDR_W'(col_q);
          if (col_q == COL_W'(SPR_W - 1)) state_d = BAND;
          else                            col_d   = col_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/brick_sprite_reader.sv
// Brick sprite read side: address generator plus hit/index realignment pipeline.
// Optional BRICK_TRANSPARENT_EN makes palette index TRANSPARENT_IDX a non-hit.
module brick_sprite_reader
  import brick_pkg::*;
#(
  parameter int SPR_W = DEF_SPR_W,
  parameter int SPR_H = DEF_SPR_H
)
(
  input  logic              CLK,
  input  logic              Reset,
  input  logic [PIX_W-1:0]  DrawX,
  input  logic [PIX_W-1:0]  DrawY,
  input  logic              blank_n,
  input  logic [PIX_W-1:0]  SprX,
  input  logic [PIX_W-1:0]  SprY,
  input  logic [3:0]        ram_data,
  output logic [ADDR_W-1:0] READ_ADDR,
  output logic [3:0]        pixel_index,
  output logic              pixel_hit
);

  logic hit_s1;
  logic hit_s2;
  logic opaque;

  brick_addr_gen #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_addr_gen (
    .CLK       (CLK),
    .Reset     (Reset),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .blank_n   (blank_n),
    .SprX      (SprX),
    .SprY      (SprY),
    .READ_ADDR (READ_ADDR),
    .hit_s1    (hit_s1)
  );

`ifdef BRICK_TRANSPARENT_EN
  assign opaque = (ram_data != TRANSPARENT_IDX);
`else
  assign opaque = 1'b1;
`endif

  // hit_s2 covers the RAM's registered read so the flag meets its data.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      hit_s2      <= 1'b0;
      pixel_hit   <= 1'b0;
      pixel_index <= '0;
    end else begin
      hit_s2      <= hit_s1;
      pixel_index <= ram_data;
      pixel_hit   <= hit_s2 && opaque;
    end
  end

endmodule
